demux1x2_buf: RTL and testbench

- Inverse of the datapath 2:1 select: steers one WIDTH-bit input stream to one of two destinations chosen by S.
- Each destination has its own DEPTH-entry FIFO with valid/ready handshakes, so one stalled consumer does not lose data.
- Sits between a single result producer (e.g. ALU/memory return path) and two consumers (e.g. register-file write port and I/O port).

---
 rtl/demux1x2_buf.sv | 82 ++++++++
 tb/tb_demux1x2_buf.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/demux1x2_buf.sv
// 1:2 demultiplexer with a DEPTH-entry valid/ready FIFO per destination.
// S picks the destination FIFO; each consumer drains its own FIFO independently.
module demux1x2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             S,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y0,
  output logic             Y0_VALID,
  input  logic             Y0_READY,
  output logic [WIDTH-1:0] Y1,
  output logic             Y1_VALID,
  input  logic             Y1_READY,
  output logic [CW-1:0]    CNT0,
  output logic [CW-1:0]    CNT1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0] out_ready;
  assign out_ready = {Y1_READY, Y0_READY};

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    localparam logic SEL = 1'(n);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             valid;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign full  = (cnt == FULL_CNT);
    assign valid = (cnt != '0);
    // A full FIFO refuses the push even when it is popped in the same cycle.
    assign push  = IN_VALID && !full && (S == SEL);
    assign pop   = valid && out_ready[n];
    assign head  = valid ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (!push && pop) cnt <= cnt - CW'(1);
      end
    end

    // NOTE: storage is deliberately left out of reset; the count alone decides
    // which entries are meaningful, and skipping reset keeps the array as plain RAM.
    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= D;
    end
  end

  assign IN_READY = S ? !g_fifo[1].full : !g_fifo[0].full;

  assign Y0       = g_fifo[0].head;
  assign Y0_VALID = g_fifo[0].valid;
  assign CNT0     = g_fifo[0].cnt;

  assign Y1       = g_fifo[1].head;
  assign Y1_VALID = g_fifo[1].valid;
  assign CNT1     = g_fifo[1].cnt;

endmodule

// File: tb/tb_demux1x2_buf.sv
// Directed table-driven bench for demux1x2_buf plus a streaming wrap sequence.
// Inputs change on the falling edge; outputs are compared 2 ns later.
module tb_demux1x2_buf;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] D = '0;
  logic        S = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] Y0;
  logic        Y0_VALID;
  logic        Y0_READY = 1'b0;
  logic [31:0] Y1;
  logic        Y1_VALID;
  logic        Y1_READY = 1'b0;
  logic [1:0]  CNT0;
  logic [1:0]  CNT1;

  demux1x2_buf #(.WIDTH(32), .DEPTH(2), .CW(2)) dut (
    .CLK(CLK), .RST(RST), .D(D), .S(S), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Y0(Y0), .Y0_VALID(Y0_VALID), .Y0_READY(Y0_READY),
    .Y1(Y1), .Y1_VALID(Y1_VALID), .Y1_READY(Y1_READY),
    .CNT0(CNT0), .CNT1(CNT1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          iv;
    bit          s;
    logic [31:0] d;
    bit          r0;
    bit          r1;
    bit          ir;
    bit          v0;
    logic [31:0] y0;
    bit          v1;
    logic [31:0] y1;
    int          c0;
    int          c1;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void add(input bit chk, input bit rst, input bit iv, input bit s,
                              input logic [31:0] d, input bit r0, input bit r1,
                              input bit ir, input bit v0, input logic [31:0] y0,
                              input bit v1, input logic [31:0] y1, input int c0, input int c1);
    vec_t v;
    v.chk = chk; v.rst = rst; v.iv = iv; v.s = s; v.d = d; v.r0 = r0; v.r1 = r1;
    v.ir = ir; v.v0 = v0; v.y0 = y0; v.v1 = v1; v.y1 = y1; v.c0 = c0; v.c1 = c1;
    vecs.push_back(v);
  endfunction

  task automatic drive(input bit rst, input bit iv, input bit s, input logic [31:0] d,
                       input bit r0, input bit r1);
    RST = rst; IN_VALID = iv; S = s; D = d; Y0_READY = r0; Y1_READY = r1;
  endtask

  initial begin
    // chk rst iv s  d             r0 r1 | ir v0 y0           v1 y1           c0 c1
    // reset then idle
    add(0, 1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 1, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    // basic steering, then drain both
    add(1, 0, 1, 0, 32'h11111111, 0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 1, 1, 32'h22222222, 0, 0,   1, 1, 32'h11111111, 0, 32'h0,        1, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h11111111, 1, 32'h22222222, 1, 1);
    add(1, 0, 0, 0, 32'h0,        1, 1,   1, 1, 32'h11111111, 1, 32'h22222222, 1, 1);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    // fill FIFO 0, backpressure, pop one, refill, FIFO 1 unaffected
    add(1, 0, 1, 0, 32'hA0,       0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 1, 0, 32'hA1,       0, 0,   1, 1, 32'hA0,       0, 32'h0,        1, 0);
    add(1, 0, 1, 0, 32'hA2,       0, 0,   0, 1, 32'hA0,       0, 32'h0,        2, 0);
    add(1, 0, 1, 0, 32'hA2,       1, 0,   0, 1, 32'hA0,       0, 32'h0,        2, 0);
    add(1, 0, 1, 0, 32'hA2,       0, 0,   1, 1, 32'hA1,       0, 32'h0,        1, 0);
    add(1, 0, 1, 1, 32'hB0,       0, 0,   1, 1, 32'hA1,       0, 32'h0,        2, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   0, 1, 32'hA1,       1, 32'hB0,       2, 1);
    // reset mid-operation with a word offered that FIFO 1 could accept
    add(1, 1, 1, 1, 32'hCCCCCCCC, 0, 0,   1, 1, 32'hA1,       1, 32'hB0,       2, 1);
    add(1, 0, 0, 1, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    // underflow guard, then a push while the consumer is still asserting ready
    add(1, 0, 0, 0, 32'h0,        1, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 32'h0,        1, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 32'h0,        1, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 1, 0, 32'h5A5A5A5A, 1, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h5A5A5A5A, 0, 32'h0,        1, 0);
    add(1, 0, 0, 0, 32'h0,        1, 0,   1, 1, 32'h5A5A5A5A, 0, 32'h0,        1, 0);
    add(1, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        0, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].iv, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #2;
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i), 32'(IN_READY), 32'(vecs[i].ir));
        check($sformatf("v%0d y0_valid", i), 32'(Y0_VALID), 32'(vecs[i].v0));
        check($sformatf("v%0d y0", i),       Y0,            vecs[i].y0);
        check($sformatf("v%0d y1_valid", i), 32'(Y1_VALID), 32'(vecs[i].v1));
        check($sformatf("v%0d y1", i),       Y1,            vecs[i].y1);
        check($sformatf("v%0d cnt0", i),     32'(CNT0),     32'(vecs[i].c0));
        check($sformatf("v%0d cnt1", i),     32'(CNT1),     32'(vecs[i].c1));
      end
    end

    // Stream 1..10 into FIFO 1 with the consumer always ready: wraps the pointers
    // several times while occupancy stays at one.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(0, 1, 1, 32'(i + 1), 0, 1);
      #2;
      check($sformatf("stream%0d in_ready", i), 32'(IN_READY), 32'd1);
      check($sformatf("stream%0d y1_valid", i), 32'(Y1_VALID), (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("stream%0d y1", i),       Y1,            32'(i));
      check($sformatf("stream%0d cnt1", i),     32'(CNT1),     (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("stream%0d cnt0", i),     32'(CNT0),     32'd0);
    end
    @(negedge CLK);
    drive(0, 0, 1, 32'h0, 0, 1);
    #2;
    check("stream_tail y1",   Y1,        32'd10);
    check("stream_tail cnt1", 32'(CNT1), 32'd1);
    @(negedge CLK);
    drive(0, 0, 0, 32'h0, 0, 0);
    #2;
    check("stream_end y1_valid", 32'(Y1_VALID), 32'd0);
    check("stream_end cnt1",     32'(CNT1),     32'd0);
    check("stream_end y1",       Y1,            32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
